// File: rtl/vga_fml_wb_bridge_pkg.sv
// Shared types and constants for the VGA FML-to-Wishbone bridge.
package vga_fml_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS = 2;
  localparam logic [LINE_BITS-1:0] LAST_WORD = LINE_BITS'(LINE_WORDS - 1);
  localparam logic [15:0] TMO_DATA = 16'hFFFF;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic [1:0] sel);
    merge_bytes[7:0]  = sel[0] ? new_word[7:0]  : old_word[7:0];
    merge_bytes[15:8] = sel[1] ? new_word[15:8] : old_word[15:8];
  endfunction

endpackage

// File: rtl/vga_fml_wb_bridge_line_buf.sv
// One-line (4 x 16) read buffer: full-word fill port, byte-merge write port, async read.
module vga_fml_wb_bridge_line_buf
  import vga_fml_wb_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 fill_en,
  input  logic [LINE_BITS-1:0] fill_idx,
  input  logic [15:0]          fill_data,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_idx,
  input  logic [1:0]           wr_sel,
  input  logic [15:0]          wr_data,
  input  logic [LINE_BITS-1:0] rd_idx,
  output logic [15:0]          rd_data
);

  logic [15:0] words [LINE_WORDS];

  // Fill and merge never coincide: they belong to different FSM states.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      words[fill_idx] <= fill_data;
    end else if (wr_en) begin
      words[wr_idx] <= merge_bytes(words[wr_idx], wr_data, wr_sel);
    end
  end

  assign rd_data = words[rd_idx];

endmodule

// File: rtl/vga_fml_wb_bridge.sv
// FML responder serving single-word reads from a 4-word line buffer filled by
// Wishbone bursts; writes are forwarded one-for-one and merged into the line on a hit.
module vga_fml_wb_bridge
  import vga_fml_wb_bridge_pkg::*;
#(
  parameter int fml_depth = 20,
  parameter int tmo_bits  = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [fml_depth-1:0] fml_adr_i,
  input  logic                 fml_stb_i,
  input  logic                 fml_we_i,
  input  logic [1:0]           fml_sel_i,
  input  logic [15:0]          fml_di,
  output logic [15:0]          fml_do,
  output logic                 fml_ack_o,
  output logic [fml_depth-2:0] wbm_adr_o,
  output logic [15:0]          wbm_dat_o,
  input  logic [15:0]          wbm_dat_i,
  output logic [1:0]           wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  input  logic                 wbm_ack_i,
  output logic                 err_o
);

  // Abort fires on the (2^tmo_bits - 1)-th consecutive cycle without an ack.
  localparam logic [tmo_bits-1:0] TMO_LAST = tmo_bits'((1 << tmo_bits) - 2);

  state_t                 state, state_next;
  logic                   valid;
  logic [fml_depth-4:0]   line_tag;
  logic [LINE_BITS-1:0]   wc;
  logic [tmo_bits-1:0]    tmo_cnt;
  logic [fml_depth-4:0]   tag;
  logic [LINE_BITS-1:0]   idx;
  logic                   hit;
  logic                   busy;
  logic                   timeout;
  logic                   fill_last;
  logic [15:0]            buf_rd;
  logic                   unused_adr0;

  assign tag         = fml_adr_i[fml_depth-1:3];
  assign idx         = fml_adr_i[2:1];
  assign unused_adr0 = fml_adr_i[0];
  assign hit         = valid && (tag == line_tag);
  assign busy        = (state == ST_FILL) || (state == ST_WRITE);
  assign timeout     = busy && wbm_cyc_o && !wbm_ack_i && (tmo_cnt == TMO_LAST);
  assign fill_last   = (state == ST_FILL) && wbm_ack_i && (wc == LAST_WORD);

  vga_fml_wb_bridge_line_buf u_line_buf (
    .clk       (wb_clk_i),
    .fill_en   ((state == ST_FILL) && wbm_ack_i),
    .fill_idx  (wc),
    .fill_data (wbm_dat_i),
    .wr_en     ((state == ST_WRITE) && wbm_ack_i && hit),
    .wr_idx    (idx),
    .wr_sel    (fml_sel_i),
    .wr_data   (fml_di),
    .rd_idx    (idx),
    .rd_data   (buf_rd)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fml_stb_i) begin
          if (fml_we_i)  state_next = ST_WRITE;
          else if (hit)  state_next = ST_ACK;
          else           state_next = ST_FILL;
        end
      end
      ST_FILL:  if (fill_last || timeout) state_next = ST_ACK;
      ST_WRITE: if (wbm_ack_i || timeout) state_next = ST_ACK;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fml_ack_o = (state == ST_ACK);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      valid     <= 1'b0;
      line_tag  <= '0;
      wc        <= '0;
      tmo_cnt   <= '0;
      err_o     <= 1'b0;
      fml_do    <= 16'h0000;
      wbm_adr_o <= '0;
      wbm_dat_o <= 16'h0000;
      wbm_sel_o <= 2'b00;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (fml_stb_i) begin
            if (fml_we_i) begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= fml_adr_i[fml_depth-1:1];
              wbm_dat_o <= fml_di;
              wbm_sel_o <= fml_sel_i;
            end else if (hit) begin
              fml_do <= buf_rd;
            end else begin
              valid     <= 1'b0;
              wc        <= '0;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              wbm_sel_o <= 2'b11;
              wbm_adr_o <= {tag, {LINE_BITS{1'b0}}};
            end
          end
        end
        ST_FILL, ST_WRITE: begin
          if (wbm_ack_i) begin
            tmo_cnt <= '0;
            if (state == ST_WRITE) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_we_o  <= 1'b0;
            end else begin
              wc        <= wc + 1'b1;
              wbm_adr_o <= {tag, wc + 1'b1};
              if (wc == LAST_WORD) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                valid     <= 1'b1;
                line_tag  <= tag;
                // The last word lands in the buffer on this same edge.
                fml_do    <= (idx == LAST_WORD) ? wbm_dat_i : buf_rd;
              end
            end
          end else if (timeout) begin
            tmo_cnt   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            valid     <= 1'b0;
            err_o     <= 1'b1;
            fml_do    <= TMO_DATA;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
